local_bht_update_queue: RTL

In-order tracker for predicted branches between fetch and resolution, driving the update side of the local BHT. Each fetched branch's PC and predicted direction are queued. When the branch resolves in execute, the block compares the actual outcome with the queued prediction, issues a registered BHT write (pc, taken, write strobe), and reports a misprediction that flushes all younger queued branches. It sits between the fetch stage (BHT read/predict port) and the execute stage (branch resolution).

---
 rtl/local_bht_update_queue_if.sv | 34 +++
 rtl/local_bht_update_queue.sv | 89 ++++++++
 2 files changed

// File: rtl/local_bht_update_queue_if.sv
// Fetch/resolve/update bundle for the local BHT update queue.
// The master side is the pipeline; the slave side is the queue itself.
interface local_bht_update_queue_if;
    logic        fetch_valid;
    logic [15:0] fetch_pc;
    logic        fetch_prediction;
    logic        resolve_valid;
    logic [15:0] resolve_pc;
    logic        resolve_taken;
    logic        flush;
    logic        full;
    logic        empty;
    logic        bht_write;
    logic [15:0] bht_write_pc;
    logic        bht_taken;
    logic        mispredict;
    logic        sync_error;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    modport master (
        output fetch_valid, fetch_pc, fetch_prediction,
        output resolve_valid, resolve_pc, resolve_taken, flush,
        input  full, empty, bht_write, bht_write_pc, bht_taken,
        input  mispredict, sync_error, branch_count, mispredict_count
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_prediction,
        input  resolve_valid, resolve_pc, resolve_taken, flush,
        output full, empty, bht_write, bht_write_pc, bht_taken,
        output mispredict, sync_error, branch_count, mispredict_count
    );
endinterface

// File: rtl/local_bht_update_queue.sv
// In-order queue of predicted branches; on resolve it issues a registered
// BHT write and flushes younger entries when the prediction was wrong.
module local_bht_update_queue #(
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    local_bht_update_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [15:0] pc;
        logic        pred;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;

    logic        bht_write_q, bht_taken_q, mispredict_q, sync_error_q;
    logic [15:0] bht_pc_q, branch_cnt_q, mispred_cnt_q;

    entry_t head_e;
    logic   full, empty, res_ok, res_bad, mis, clear, enq_ok;

    assign head_e  = mem[head];
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign res_ok  = bus.resolve_valid && !empty && (bus.resolve_pc == head_e.pc);
    assign res_bad = bus.resolve_valid && !res_ok;
    assign mis     = res_ok && (bus.resolve_taken != head_e.pred);
    // A fetched branch is always younger than anything being flushed, so it dies too.
    assign clear   = bus.flush || mis;
    assign enq_ok  = bus.fetch_valid && (!full || res_ok) && !clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_ok) tail <= tail + PW'(1);
            if (res_ok) head <= head + PW'(1);
            count <= count + (PW+1)'(enq_ok) - (PW+1)'(res_ok);
        end
    end

    // Storage is qualified by the pointers, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && enq_ok) mem[tail] <= '{pc: bus.fetch_pc, pred: bus.fetch_prediction};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bht_write_q   <= 1'b0;
            bht_pc_q      <= '0;
            bht_taken_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            sync_error_q  <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            bht_write_q  <= res_ok;
            mispredict_q <= mis;
            if (res_ok) begin
                bht_pc_q     <= bus.resolve_pc;
                bht_taken_q  <= bus.resolve_taken;
                branch_cnt_q <= branch_cnt_q + 16'd1;
            end
            if (mis) mispred_cnt_q <= mispred_cnt_q + 16'd1;
            if (res_bad) sync_error_q <= 1'b1;
        end
    end

    assign bus.full             = full;
    assign bus.empty            = empty;
    assign bus.bht_write        = bht_write_q;
    assign bus.bht_write_pc     = bht_pc_q;
    assign bus.bht_taken        = bht_taken_q;
    assign bus.mispredict       = mispredict_q;
    assign bus.sync_error       = sync_error_q;
    assign bus.branch_count     = branch_cnt_q;
    assign bus.mispredict_count = mispred_cnt_q;
endmodule
